if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline. It sits directly upstream of the IF/ID pipeline register.
- Owns the PC.
- Issues single-word requests to an instruction memory of variable latency.
- Buffers one returned instruction in an output slot and presents it with PC+4 to the IF/ID register.
- Handles hazard stalls and branch/jump redirects, discarding stale in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset.
NOP_INST, 32'h0000_0000, instruction driven on inst when the slot is empty.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset; asynchronous, active-high.
stall  in  1  IF/ID not loading this cycle (hazard unit drives it as the inverse of IF/ID ld); the output slot must be held.
redirect  in  1  taken branch/jump; overrides stall.
redirect_pc  in  32  new fetch address, valid when redirect=1.
imem_req  out  1  request strobe, one cycle per request.
imem_addr  out  32  request address; always equals pc.
imem_rvalid  in  1  response valid; earliest one cycle after imem_req.
imem_rdata  in  32  response instruction word.
inst  out  32  instruction to IF/ID.
PC_4  out  32  address of inst plus 4.
inst_valid  out  1  output slot holds a valid instruction.

Behaviour:
- State registers:
  - pc: next fetch address.
  - busy: one request outstanding.
  - drop: outstanding response is stale.
  - slot: out_valid, out_inst, out_pc4.
- Reset (async, immediate, no clock needed):
  - pc=RESET_PC; busy=0; drop=0; out_valid=0; out_inst=0; out_pc4=0.
  - imem_req=0 while rst=1; inst=NOP_INST; PC_4=0; inst_valid=0.
- Outputs:
  - inst = out_valid ? out_inst : NOP_INST.
  - PC_4 = out_pc4; it holds its last value when the slot is empty.
  - inst_valid = out_valid.
- At most one request outstanding. imem_rvalid while busy=0 is ignored (covers late responses after reset).
- Issue (combinational): imem_req = !rst && !busy && !redirect && (!out_valid || !stall).
  - On issue: busy<=1, pc<=pc+4 (32-bit wrap, 0xFFFF_FFFC -> 0x0000_0000).
- Response (imem_rvalid && busy), without redirect:
  - busy<=0.
  - If drop=1: drop<=0, data discarded.
  - Else: out_valid<=1, out_inst<=imem_rdata, out_pc4<=pc. pc already equals request address + 4.
  - The slot is guaranteed free here, by the issue rule.
- Consume: out_valid && !stall && !redirect clears out_valid, unless the same cycle refills it.
- Redirect (highest priority, regardless of stall):
  - pc<=redirect_pc; out_valid<=0; no issue this cycle.
  - If busy and no rvalid this cycle: drop<=1.
  - If rvalid this cycle: response discarded, busy<=0, drop<=0.
  - A redirect while drop=1 just updates pc.
  - The next request goes out at redirect_pc once busy=0.
- Throughput with 1-cycle memory: one instruction per 2 cycles (issue, then response; the next issue is the cycle after the response).
- Stall with empty slot: a request may still issue. Its response fills the slot and is held until stall falls.
- Reset mid-operation: in-flight request abandoned; first post-reset request goes to RESET_PC on the first cycle with rst=0.

Test Plan:
- Reset, 1-cycle memory returning addr-tagged words, no stall -> imem_addr 0x0,0x4,0x8 every 2 cycles; inst_valid=1 with PC_4 0x4,0x8,0xC and matching inst.
- Slot valid at PC_4=0x8, stall=1 for 3 cycles -> inst/PC_4 constant, imem_req=0 throughout; stall falls -> imem_req=1 at addr 0x8 that cycle, slot cleared next edge.
- 3-cycle memory, redirect=1 redirect_pc=0x100 one cycle after request to 0x4 -> response for 0x4 discarded (inst_valid stays 0); next imem_req at 0x100 the cycle after stale rvalid; then inst_valid with PC_4=0x104.
- Redirect to 0x200 in the same cycle as imem_rvalid -> data discarded; imem_req at 0x200 the next cycle.
- Slot valid, stall=1, redirect=1 to 0x40 -> next edge inst_valid=0, inst=NOP_INST; next request at 0x40.
- rst pulsed mid-wait, without a clock edge -> outputs clear immediately; a late imem_rvalid is ignored; first request at RESET_PC.
- pc=0xFFFF_FFFC issue -> next request at 0x0; PC_4 reported 0x0.

Source files
------------

// File: rtl/if_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_if
// Description : Instruction-memory request/response bundle between the fetch
//               stage and the instruction memory.
//               master (fetch side): drives imem_req / imem_addr,
//                                    receives imem_rvalid / imem_rdata.
//               slave  (memory side): the mirror image.
// Revision    : 1.0 - initial release
// ============================================================================
interface if_fetch_if;
  logic        imem_req;     // one-cycle request strobe
  logic [31:0] imem_addr;    // request address
  logic        imem_rvalid;  // response valid
  logic [31:0] imem_rdata;   // response instruction word

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch
// Description : Instruction-fetch stage of a 5-stage MIPS pipeline. Owns the
//               PC, keeps at most one request outstanding to a variable
//               latency instruction memory, buffers one returned instruction
//               in an output slot for the IF/ID register, and handles hazard
//               stalls and branch/jump redirects (stale responses dropped).
// Ports       : clk, rst          - clock, async active-high reset
//               imem (master)     - instruction memory request/response
//               stall             - IF/ID not loading; slot must be held
//               redirect/_pc      - taken branch/jump and its target
//               inst/PC_4         - instruction and its address + 4
//               inst_valid        - output slot holds an instruction
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  wire logic        clk,
  input  wire logic        rst,
  if_fetch_if.master       imem,
  input  wire logic        stall,
  input  wire logic        redirect,
  input  wire logic [31:0] redirect_pc,
  output logic [31:0]      inst,
  output logic [31:0]      PC_4,
  output logic             inst_valid
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [31:0] pc_q,        pc_d;         // next fetch address
  logic        busy_q,      busy_d;       // one request outstanding
  logic        drop_q,      drop_d;       // outstanding response is stale
  logic        out_valid_q, out_valid_d;  // output slot occupied
  logic [31:0] out_inst_q,  out_inst_d;
  logic [31:0] out_pc4_q,   out_pc4_d;

  logic issue;
  logic resp;

  // A new request may go out only when nothing is in flight, no redirect is
  // pending, and the slot will be free by the time the response lands
  // (either empty now, or being consumed this cycle).
  assign issue = !rst && !busy_q && !redirect && (!out_valid_q || !stall);

  // Responses while idle (e.g. late returns after reset) are ignored.
  assign resp  = imem.imem_rvalid && busy_q;

  assign imem.imem_req  = issue;
  assign imem.imem_addr = pc_q;

  assign inst       = out_valid_q ? out_inst_q : NOP_INST;
  assign PC_4       = out_pc4_q;
  assign inst_valid = out_valid_q;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    pc_d        = pc_q;
    busy_d      = busy_q;
    drop_d      = drop_q;
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_pc4_d   = out_pc4_q;

    if (redirect) begin
      // Redirect wins over stall and flushes the slot.
      pc_d        = redirect_pc;
      out_valid_d = 1'b0;
      if (busy_q) begin
        if (imem.imem_rvalid) begin
          // Response arrives together with the redirect: throw it away now.
          busy_d = 1'b0;
          drop_d = 1'b0;
        end else begin
          // Still waiting: the eventual response belongs to the old path.
          drop_d = 1'b1;
        end
      end
    end else begin
      if (out_valid_q && !stall) begin
        out_valid_d = 1'b0;
      end

      if (resp) begin
        busy_d = 1'b0;
        if (drop_q) begin
          drop_d = 1'b0;
        end else begin
          // pc already advanced past the request address at issue time,
          // so it is exactly the request address + 4.
          out_valid_d = 1'b1;
          out_inst_d  = imem.imem_rdata;
          out_pc4_d   = pc_q;
        end
      end

      // issue requires !busy, so it never coincides with a response.
      if (issue) begin
        busy_d = 1'b1;
        pc_d   = pc_q + 32'd4;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      busy_q      <= 1'b0;
      drop_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_inst_q  <= 32'h0000_0000;
      out_pc4_q   <= 32'h0000_0000;
    end else begin
      pc_q        <= pc_d;
      busy_q      <= busy_d;
      drop_q      <= drop_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_pc4_q   <= out_pc4_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch
// Description : Self-checking bench for if_fetch: directed vector tables,
//               hand-written corner sequences, and randomized traffic
//               against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch;

  localparam logic [31:0] C_NOP = 32'hDEAD_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] inst;
  logic [31:0] pc_4;
  logic        inst_valid;

  if_fetch_if bus ();

  if_fetch #(
    .RESET_PC (32'h0000_0000),
    .NOP_INST (C_NOP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (bus.master),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst        (inst),
    .PC_4        (pc_4),
    .inst_valid  (inst_valid)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  function automatic logic [31:0] tagw(input logic [31:0] a);
    return a ^ 32'h1234_0000;
  endfunction

  task automatic check(input string name, input logic e_req, input logic [31:0] e_addr,
                       input logic e_valid, input logic [31:0] e_inst, input logic [31:0] e_pc4);
    checks++;
    if (bus.imem_req !== e_req || bus.imem_addr !== e_addr || inst_valid !== e_valid ||
        inst !== e_inst || pc_4 !== e_pc4) begin
      failures++;
      $display("FAIL %s: got req=%b addr=%h valid=%b inst=%h pc4=%h, expected req=%b addr=%h valid=%b inst=%h pc4=%h",
               name, bus.imem_req, bus.imem_addr, inst_valid, inst, pc_4,
               e_req, e_addr, e_valid, e_inst, e_pc4);
    end
  endtask

  // One cycle of stimulus: applied after the falling edge, outputs sampled 1ns later.
  task automatic drive(input logic s, input logic r, input logic [31:0] rp,
                       input logic v, input logic [31:0] d);
    @(negedge clk);
    rst             = 1'b0;
    stall           = s;
    redirect        = r;
    redirect_pc     = rp;
    bus.imem_rvalid = v;
    bus.imem_rdata  = d;
    #1;
  endtask

  // Holds reset across two rising edges; the next drive() releases it.
  task automatic do_reset();
    @(negedge clk);
    rst             = 1'b1;
    stall           = 1'b0;
    redirect        = 1'b0;
    redirect_pc     = 32'h0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    #1;
    check("reset_state", 1'b0, 32'h0, 1'b0, C_NOP, 32'h0);
    @(posedge clk);
    @(posedge clk);
  endtask

  // --------------------------------------------------------------------------
  // Directed vector table
  // --------------------------------------------------------------------------
  typedef struct {
    logic        pre_rst;
    logic        s;
    logic        r;
    logic [31:0] rp;
    logic        v;
    logic [31:0] d;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_pc4;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic pr, logic s, logic r, logic [31:0] rp, logic v, logic [31:0] d,
                              logic er, logic [31:0] ea, logic ev, logic [31:0] ei, logic [31:0] ep);
    vec_t t;
    t.pre_rst = pr; t.s = s; t.r = r; t.rp = rp; t.v = v; t.d = d;
    t.e_req = er; t.e_addr = ea; t.e_valid = ev; t.e_inst = ei; t.e_pc4 = ep;
    return t;
  endfunction

  // --------------------------------------------------------------------------
  // Reference model: fetch in terms of in-flight transactions and a slot
  // --------------------------------------------------------------------------
  typedef struct { logic [31:0] addr; logic stale; } flight_t;
  typedef struct { logic [31:0] addr; int due; } mem_t;

  flight_t     m_flight[$];
  mem_t        mem_q[$];
  logic [31:0] m_pc;
  logic        m_slot_v;
  logic [31:0] m_slot_inst;
  logic [31:0] m_slot_pc4;

  initial begin
    int          cyc;
    logic        s, r, v;
    logic [31:0] rp, d, tmp;
    logic        e_req;
    flight_t     f;

    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;

    // Straight-line fetch with 1-cycle memory, then a 3-cycle stall.
    vecs.push_back(mk(1,0,0,0,0,0,               1,32'h0, 0,C_NOP,32'h0));
    vecs.push_back(mk(0,0,0,0,1,tagw(32'h0),     0,32'h4, 0,C_NOP,32'h0));
    vecs.push_back(mk(0,0,0,0,0,0,               1,32'h4, 1,tagw(32'h0),32'h4));
    vecs.push_back(mk(0,0,0,0,1,tagw(32'h4),     0,32'h8, 0,C_NOP,32'h4));
    vecs.push_back(mk(0,1,0,0,0,0,               0,32'h8, 1,tagw(32'h4),32'h8));
    vecs.push_back(mk(0,1,0,0,0,0,               0,32'h8, 1,tagw(32'h4),32'h8));
    vecs.push_back(mk(0,1,0,0,0,0,               0,32'h8, 1,tagw(32'h4),32'h8));
    vecs.push_back(mk(0,0,0,0,0,0,               1,32'h8, 1,tagw(32'h4),32'h8));
    vecs.push_back(mk(0,0,0,0,1,tagw(32'h8),     0,32'hC, 0,C_NOP,32'h8));
    vecs.push_back(mk(0,0,0,0,0,0,               1,32'hC, 1,tagw(32'h8),32'hC));
    vecs.push_back(mk(0,0,0,0,1,tagw(32'hC),     0,32'h10,0,C_NOP,32'hC));
    // 3-cycle memory, redirect while waiting, redirect with rvalid, stall+redirect.
    vecs.push_back(mk(1,0,0,0,0,0,               1,32'h0,  0,C_NOP,32'h0));
    vecs.push_back(mk(0,0,0,0,0,0,               0,32'h4,  0,C_NOP,32'h0));
    vecs.push_back(mk(0,0,0,0,0,0,               0,32'h4,  0,C_NOP,32'h0));
    vecs.push_back(mk(0,0,0,0,1,tagw(32'h0),     0,32'h4,  0,C_NOP,32'h0));
    vecs.push_back(mk(0,0,0,0,0,0,               1,32'h4,  1,tagw(32'h0),32'h4));
    vecs.push_back(mk(0,0,1,32'h100,0,0,         0,32'h8,  0,C_NOP,32'h4));
    vecs.push_back(mk(0,0,0,0,0,0,               0,32'h100,0,C_NOP,32'h4));
    vecs.push_back(mk(0,0,0,0,1,tagw(32'h4),     0,32'h100,0,C_NOP,32'h4));
    vecs.push_back(mk(0,0,0,0,0,0,               1,32'h100,0,C_NOP,32'h4));
    vecs.push_back(mk(0,0,0,0,0,0,               0,32'h104,0,C_NOP,32'h4));
    vecs.push_back(mk(0,0,0,0,0,0,               0,32'h104,0,C_NOP,32'h4));
    vecs.push_back(mk(0,0,0,0,1,tagw(32'h100),   0,32'h104,0,C_NOP,32'h4));
    vecs.push_back(mk(0,0,0,0,0,0,               1,32'h104,1,tagw(32'h100),32'h104));
    vecs.push_back(mk(0,0,1,32'h200,1,tagw(32'h104), 0,32'h108,0,C_NOP,32'h104));
    vecs.push_back(mk(0,0,0,0,0,0,               1,32'h200,0,C_NOP,32'h104));
    vecs.push_back(mk(0,0,0,0,1,tagw(32'h200),   0,32'h204,0,C_NOP,32'h104));
    vecs.push_back(mk(0,1,0,0,0,0,               0,32'h204,1,tagw(32'h200),32'h204));
    vecs.push_back(mk(0,1,1,32'h40,0,0,          0,32'h204,1,tagw(32'h200),32'h204));
    vecs.push_back(mk(0,1,0,0,0,0,               1,32'h40, 0,C_NOP,32'h204));
    vecs.push_back(mk(0,1,0,0,1,tagw(32'h40),    0,32'h44, 0,C_NOP,32'h204));
    vecs.push_back(mk(0,1,0,0,0,0,               0,32'h44, 1,tagw(32'h40),32'h44));
    vecs.push_back(mk(0,0,0,0,0,0,               1,32'h44, 1,tagw(32'h40),32'h44));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].pre_rst) do_reset();
      drive(vecs[i].s, vecs[i].r, vecs[i].rp, vecs[i].v, vecs[i].d);
      check($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
            vecs[i].e_inst, vecs[i].e_pc4);
    end

    // Async reset mid-wait (request to 0x44 outstanding), released before the
    // next edge while a late rvalid is presented.
    @(negedge clk);
    stall = 1'b0; redirect = 1'b0;
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hBAD0_BAD0;
    #1 rst = 1'b1;
    #1 check("rst_async", 1'b0, 32'h0, 1'b0, C_NOP, 32'h0);
    #1 rst = 1'b0;
    #1 check("rst_release", 1'b1, 32'h0, 1'b0, C_NOP, 32'h0);
    drive(0, 0, 0, 0, 0);
    check("rst_wait", 1'b0, 32'h4, 1'b0, C_NOP, 32'h0);
    drive(0, 0, 0, 1, tagw(32'h0));
    check("rst_resp", 1'b0, 32'h4, 1'b0, C_NOP, 32'h0);
    drive(0, 0, 0, 0, 0);
    check("rst_first", 1'b1, 32'h4, 1'b1, tagw(32'h0), 32'h4);

    // PC wrap at the top of the address space.
    do_reset();
    drive(0, 1, 32'hFFFF_FFFC, 0, 0);
    check("wrap_redir", 1'b0, 32'h0, 1'b0, C_NOP, 32'h0);
    drive(0, 0, 0, 0, 0);
    check("wrap_issue", 1'b1, 32'hFFFF_FFFC, 1'b0, C_NOP, 32'h0);
    drive(0, 0, 0, 1, tagw(32'hFFFF_FFFC));
    check("wrap_resp", 1'b0, 32'h0, 1'b0, C_NOP, 32'h0);
    drive(0, 0, 0, 0, 0);
    check("wrap_slot", 1'b1, 32'h0, 1'b1, tagw(32'hFFFF_FFFC), 32'h0);

    // Randomized traffic against the reference model.
    do_reset();
    m_flight.delete();
    mem_q.delete();
    m_pc = 32'h0; m_slot_v = 1'b0; m_slot_inst = 32'h0; m_slot_pc4 = 32'h0;
    cyc = 0;
    for (int k = 0; k < 800; k++) begin
      v = 1'b0;
      d = $urandom;
      if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
        v = 1'b1;
        d = tagw(mem_q[0].addr);
        void'(mem_q.pop_front());
      end else if (mem_q.size() == 0 && $urandom_range(0, 9) == 0) begin
        v = 1'b1;  // spurious response while idle
      end
      s   = ($urandom_range(0, 9) < 4);
      r   = ($urandom_range(0, 11) == 0);
      tmp = $urandom;
      rp  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : {tmp[31:2], 2'b00};
      drive(s, r, rp, v, d);

      e_req = (m_flight.size() == 0) && !r && (!m_slot_v || !s);
      check($sformatf("rand%0d", k), e_req, m_pc, m_slot_v,
            m_slot_v ? m_slot_inst : C_NOP, m_slot_pc4);

      if (bus.imem_req === 1'b1)
        mem_q.push_back('{addr: bus.imem_addr, due: cyc + int'($urandom_range(1, 4))});

      // Model the coming rising edge.
      if (r) begin
        if (m_flight.size() > 0) begin
          if (v) void'(m_flight.pop_front());
          else   m_flight[0].stale = 1'b1;
        end
        m_pc     = rp;
        m_slot_v = 1'b0;
      end else begin
        if (m_slot_v && !s) m_slot_v = 1'b0;
        if (v && m_flight.size() > 0) begin
          f = m_flight.pop_front();
          if (!f.stale) begin
            m_slot_v    = 1'b1;
            m_slot_inst = d;
            m_slot_pc4  = f.addr + 32'd4;
          end
        end
        if (e_req) begin
          m_flight.push_back('{addr: m_pc, stale: 1'b0});
          m_pc = m_pc + 32'd4;
        end
      end
      cyc++;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
